// File: rtl/mcp4725_i2c_stream_if.sv
// Sample stream and open-drain I2C bus bundle for the MCP4725 streamer.
// slave = the streamer; master = sample source plus pad/slave side.
interface mcp4725_i2c_stream_if;
  logic        s_valid;
  logic        s_ready;
  logic [11:0] s_data;
  logic [1:0]  s_pd;
  logic        scl_oe;
  logic        sda_oe;
  logic        sda_in;
  logic        busy;
  logic        done;
  logic        nack;

  modport slave (
    input  s_valid, s_data, s_pd, sda_in,
    output s_ready, scl_oe, sda_oe, busy, done, nack
  );

  modport master (
    output s_valid, s_data, s_pd, sda_in,
    input  s_ready, scl_oe, sda_oe, busy, done, nack
  );
endinterface

// File: rtl/mcp4725_i2c_stream.sv
// Streams 12-bit samples to an MCP4725 with Fast-Mode writes over
// open-drain SCL/SDA; optional burst chaining of back-to-back samples.
module mcp4725_i2c_stream #(
  parameter int         CLK_DIV = 32,
  parameter logic [6:0] ADDR    = 7'h60,
  parameter bit         BURST   = 1'b1
) (
  input logic                 clk,
  input logic                 rst_n,
  mcp4725_i2c_stream_if.slave bus
);

  typedef enum logic [1:0] {IDLE, START, BITS, STOP} state_e;

  localparam logic [9:0] DIV_M1 = 10'(CLK_DIV - 1);

  state_e      st_q;
  logic [9:0]  cnt_q;
  logic [1:0]  qtr_q;
  logic [3:0]  bit_q;
  logic [1:0]  byte_q;
  logic [11:0] data_q;
  logic [1:0]  pd_q;
  logic        pend_q;
  logic        nackf_q;
  logic        scl_q;
  logic        sda_q;
  logic        rdy_q;
  logic        busy_q;
  logic        done_q;
  logic        nack_q;

  function automatic logic frame_bit(
    input logic [1:0]  idx,
    input logic [2:0]  pos,
    input logic [11:0] d,
    input logic [1:0]  pd
  );
    logic [7:0] b;
    case (idx)
      2'd0:    b = {ADDR, 1'b0};
      2'd1:    b = {2'b00, pd, d[11:8]};
      default: b = d[7:0];
    endcase
    return b[pos];
  endfunction

  logic        tick_d;
  logic        hs_d;
  logic [11:0] data_d;
  logic [1:0]  pd_d;
  logic [3:0]  nbit_d;
  logic [2:0]  bidx_d;
  logic        cur_d;
  logic        nxt_d;
  logic        b1_d;

  always_comb begin
    tick_d = (st_q != IDLE) && (cnt_q == DIV_M1);
    hs_d   = bus.s_valid && rdy_q;
    data_d = hs_d ? bus.s_data : data_q;
    pd_d   = hs_d ? bus.s_pd : pd_q;
    nbit_d = bit_q + 4'd1;
    bidx_d = 3'(4'd7 - nbit_d);
    cur_d  = frame_bit(byte_q, bidx_d, data_q, pd_q);
    nxt_d  = frame_bit(byte_q + 2'd1, 3'd7, data_q, pd_q);
    b1_d   = frame_bit(2'd1, 3'd7, data_d, pd_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      cnt_q   <= '0;
      qtr_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      data_q  <= '0;
      pd_q    <= '0;
      pend_q  <= 1'b0;
      nackf_q <= 1'b0;
      scl_q   <= 1'b0;
      sda_q   <= 1'b0;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      nack_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      nack_q <= 1'b0;
      if (hs_d) begin
        data_q <= bus.s_data;
        pd_q   <= bus.s_pd;
        rdy_q  <= 1'b0;
      end
      if (st_q == IDLE) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= tick_d ? '0 : cnt_q + 10'd1;
      end
      case (st_q)
        IDLE: begin
          if (hs_d) begin
            st_q    <= START;
            busy_q  <= 1'b1;
            sda_q   <= 1'b1;
            scl_q   <= 1'b0;
            qtr_q   <= '0;
            nackf_q <= 1'b0;
            pend_q  <= 1'b0;
          end
        end
        START: begin
          if (tick_d) begin
            if (qtr_q == 2'd0) begin
              qtr_q <= 2'd1;
              scl_q <= 1'b1;
            end else begin
              st_q   <= BITS;
              qtr_q  <= '0;
              byte_q <= '0;
              bit_q  <= '0;
              sda_q  <= ~ADDR[6];
            end
          end
        end
        BITS: begin
          // a burst sample arriving in the q3 window waits for the tick
          if (hs_d) pend_q <= 1'b1;
          if (tick_d) begin
            qtr_q <= qtr_q + 2'd1;
            case (qtr_q)
              2'd1: scl_q <= 1'b0;
              2'd2: begin
                if (bit_q == 4'd8) begin
                  if (bus.sda_in) begin
                    nack_q  <= 1'b1;
                    nackf_q <= 1'b1;
                  end else if (BURST && byte_q == 2'd2) begin
                    rdy_q <= 1'b1;
                  end
                end
              end
              2'd3: begin
                scl_q <= 1'b1;
                if (bit_q != 4'd8) begin
                  bit_q <= nbit_d;
                  sda_q <= (nbit_d == 4'd8) ? 1'b0 : ~cur_d;
                end else if (nackf_q) begin
                  st_q  <= STOP;
                  sda_q <= 1'b1;
                end else if (byte_q != 2'd2) begin
                  byte_q <= byte_q + 2'd1;
                  bit_q  <= '0;
                  sda_q  <= ~nxt_d;
                end else begin
                  done_q <= 1'b1;
                  if (pend_q || hs_d) begin
                    byte_q <= 2'd1;
                    bit_q  <= '0;
                    pend_q <= 1'b0;
                    sda_q  <= ~b1_d;
                  end else begin
                    st_q  <= STOP;
                    sda_q <= 1'b1;
                    rdy_q <= 1'b0;
                  end
                end
              end
              default: ;
            endcase
          end
        end
        STOP: begin
          if (tick_d) begin
            qtr_q <= qtr_q + 2'd1;
            case (qtr_q)
              2'd0: scl_q <= 1'b0;
              2'd1: sda_q <= 1'b0;
              default: begin
                st_q   <= IDLE;
                qtr_q  <= '0;
                busy_q <= 1'b0;
                rdy_q  <= 1'b1;
              end
            endcase
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  assign bus.s_ready = rdy_q;
  assign bus.scl_oe  = scl_q;
  assign bus.sda_oe  = sda_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.nack    = nack_q;

endmodule

// File: tb/tb_mcp4725_i2c_stream.sv
// Bench for mcp4725_i2c_stream: burst and single-shot instances,
// bus decoder with ACK/NACK slave model, timing and frame checks.
module tb_mcp4725_i2c_stream;
  localparam int DIV = 4;
  localparam int TO  = 5000;
  localparam int TS  = 256;
  localparam int TP  = 512;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mcp4725_i2c_stream_if ifb ();
  mcp4725_i2c_stream_if ifs ();

  mcp4725_i2c_stream #(
    .CLK_DIV(DIV), .ADDR(7'h60), .BURST(1'b1)
  ) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  mcp4725_i2c_stream #(
    .CLK_DIV(DIV), .ADDR(7'h60), .BURST(1'b0)
  ) u_s (.clk(clk), .rst_n(rst_n), .bus(ifs.slave));

  bit          sel = 1'b1;
  logic        v = 1'b0;
  logic [11:0] d = '0;
  logic [1:0]  pd = '0;
  logic        pull = 1'b0;

  assign ifb.s_valid = v & sel;
  assign ifb.s_data  = d;
  assign ifb.s_pd    = pd;
  assign ifb.sda_in  = ~(ifb.sda_oe | (pull & sel));
  assign ifs.s_valid = v & ~sel;
  assign ifs.s_data  = d;
  assign ifs.s_pd    = pd;
  assign ifs.sda_in  = ~(ifs.sda_oe | (pull & ~sel));

  logic m_scl, m_sda, m_rdy, m_busy, m_done, m_nack;
  assign m_scl  = sel ? ifb.scl_oe  : ifs.scl_oe;
  assign m_sda  = sel ? ifb.sda_oe  : ifs.sda_oe;
  assign m_rdy  = sel ? ifb.s_ready : ifs.s_ready;
  assign m_busy = sel ? ifb.busy    : ifs.busy;
  assign m_done = sel ? ifb.done    : ifs.done;
  assign m_nack = sel ? ifb.nack    : ifs.nack;

  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  int tok[$];
  int ex[$];
  int done_t[$];
  int nack_t[$];
  int bf_t[$];
  int rb_cnt = 0;
  bit want_nack = 1'b0;
  bit first = 1'b0;
  logic ps = 1'b1, pa = 1'b1, pb = 1'b0;
  int bc = 0;
  logic [7:0] sh = '0;

  always @(negedge clk) begin
    logic scl_l, sda_l;
    scl_l = ~m_scl;
    sda_l = ~(m_sda | pull);
    if (!rst_n) begin
      bc = 0;
      pull = 1'b0;
    end else begin
      if (ps && scl_l && pa && !sda_l) begin
        tok.push_back(TS);
        bc = 0;
        first = 1'b1;
      end else if (ps && scl_l && !pa && sda_l) begin
        tok.push_back(TP);
      end else if (!ps && scl_l) begin
        if (bc < 8) begin
          sh = {sh[6:0], sda_l};
          bc++;
          if (bc == 8) tok.push_back(int'(sh));
        end else begin
          bc = 0;
          first = 1'b0;
        end
      end else if (ps && !scl_l) begin
        pull = (bc == 8) && !(want_nack && first);
      end
      if (m_done) done_t.push_back(ecnt);
      if (m_nack) nack_t.push_back(ecnt);
      if (pb && !m_busy) bf_t.push_back(ecnt);
      if (m_busy && m_rdy) rb_cnt++;
    end
    ps = scl_l;
    pa = ~(m_sda | pull);
    pb = m_busy;
  end

  int ncmp = 0;
  int nfail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
               nm, act, act, exp, exp);
    end
  endtask

  task automatic clr();
    tok.delete();
    done_t.delete();
    nack_t.delete();
    bf_t.delete();
    rb_cnt = 0;
  endtask

  task automatic push(input logic [11:0] dd, input logic [1:0] pp,
                      output int t);
    int n;
    n = 0;
    d = dd;
    pd = pp;
    v = 1'b1;
    while (!m_rdy && n < TO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TO) chk("ready_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    t = ecnt;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_busy && n < TO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TO) chk("busy_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_log(input string nm);
    chk({nm, " ntok"}, tok.size(), ex.size());
    for (int i = 0; i < ex.size() && i < tok.size(); i++)
      chk($sformatf("%s tok%0d", nm, i), tok[i], ex[i]);
  endtask

  typedef struct {
    logic [11:0] data;
    logic [1:0]  pd;
    bit          nak;
    logic [7:0]  b1;
    logic [7:0]  b2;
  } vec_t;

  vec_t vt[5];

  initial begin
    int t, t0, t1, t2;
    vt[0] = '{12'hA5C, 2'b00, 1'b0, 8'h0A, 8'h5C};
    vt[1] = '{12'hFFF, 2'b11, 1'b0, 8'h3F, 8'hFF};
    vt[2] = '{12'h123, 2'b01, 1'b0, 8'h11, 8'h23};
    vt[3] = '{12'hA5C, 2'b00, 1'b1, 8'h00, 8'h00};
    vt[4] = '{12'h09C, 2'b10, 1'b0, 8'h20, 8'h9C};

    repeat (3) @(negedge clk);
    chk("rst scl_oe", int'(m_scl), 0);
    chk("rst sda_oe", int'(m_sda), 0);
    chk("rst busy", int'(m_busy), 0);
    chk("rst done", int'(m_done), 0);
    chk("rst nack", int'(m_nack), 0);
    chk("rst s_ready", int'(m_rdy), 1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      want_nack = vt[i].nak;
      clr();
      push(vt[i].data, vt[i].pd, t);
      v = 1'b0;
      wait_idle();
      ex.delete();
      ex.push_back(TS);
      ex.push_back(8'hC0);
      if (!vt[i].nak) begin
        ex.push_back(int'(vt[i].b1));
        ex.push_back(int'(vt[i].b2));
      end
      ex.push_back(TP);
      check_log($sformatf("vec%0d", i));
      if (vt[i].nak) begin
        chk("nak count", nack_t.size(), 1);
        chk("nak time", nack_t.size() > 0 ? nack_t[0] - t : -1, 148);
        chk("nak done", done_t.size(), 0);
        chk("nak busyfall", bf_t.size() > 0 ? bf_t[0] - t : -1, 164);
      end else begin
        chk("done count", done_t.size(), 1);
        chk("done time", done_t.size() > 0 ? done_t[0] - t : -1, 440);
        chk("busyfall", bf_t.size() > 0 ? bf_t[0] - t : -1, 452);
        chk("nack count", nack_t.size(), 0);
      end
    end
    want_nack = 1'b0;

    clr();
    push(12'h121, 2'b00, t0);
    push(12'h09C, 2'b00, t1);
    push(12'hE15, 2'b00, t2);
    v = 1'b0;
    wait_idle();
    ex = '{TS, 8'hC0, 8'h01, 8'h21, 8'h00, 8'h9C, 8'h0E, 8'h15, TP};
    check_log("burst");
    chk("burst acc1", t1 - t0, 437);
    chk("burst acc2", t2 - t1, 288);
    chk("burst ndone", done_t.size(), 3);
    if (done_t.size() == 3) begin
      chk("burst done0", done_t[0] - t0, 440);
      chk("burst gap1", done_t[1] - done_t[0], 288);
      chk("burst gap2", done_t[2] - done_t[1], 288);
    end
    chk("burst busyfall", bf_t.size() > 0 ? bf_t[0] - t0 : -1, 1028);

    sel = 1'b0;
    repeat (4) @(negedge clk);
    clr();
    push(12'h121, 2'b00, t0);
    push(12'h09C, 2'b00, t1);
    push(12'hE15, 2'b00, t2);
    v = 1'b0;
    wait_idle();
    ex = '{TS, 8'hC0, 8'h01, 8'h21, TP,
           TS, 8'hC0, 8'h00, 8'h9C, TP,
           TS, 8'hC0, 8'h0E, 8'h15, TP};
    check_log("single");
    chk("single acc1", t1 - t0, 453);
    chk("single acc2", t2 - t1, 453);
    chk("single ndone", done_t.size(), 3);
    chk("single rdy_busy", rb_cnt, 0);
    chk("single done0", done_t.size() > 0 ? done_t[0] - t0 : -1, 440);

    sel = 1'b1;
    repeat (4) @(negedge clk);
    clr();
    push(12'hA5C, 2'b00, t);
    v = 1'b0;
    repeat (202) @(negedge clk);
    chk("pre-rst busy", int'(m_busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid-rst scl_oe", int'(m_scl), 0);
    chk("mid-rst sda_oe", int'(m_sda), 0);
    chk("mid-rst busy", int'(m_busy), 0);
    chk("mid-rst s_ready", int'(m_rdy), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    clr();
    push(12'hA5C, 2'b00, t);
    v = 1'b0;
    wait_idle();
    ex = '{TS, 8'hC0, 8'h0A, 8'h5C, TP};
    check_log("post-rst");
    chk("post-rst done", done_t.size() > 0 ? done_t[0] - t : -1, 440);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
